// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch stage with a one-entry skid buffer.
//
// Issues word-aligned reads to instruction memory and presents each returned
// word, together with its fetch address + 4, to the decode stage. Decode
// backpressure (id_ready=0) is absorbed by a single skid entry; while that
// entry is full no new request is issued. A taken branch flushes the output
// and the skid entry, and redirects fetch. If a read is still outstanding
// when the branch arrives, its response is drained and discarded first.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   imem_req, imem_addr     read request and word-aligned address (held to ack)
//   imem_ack, imem_rdata    read completion and returned word
//   br_taken, br_target     redirect request and target (bits [1:0] ignored)
//   id_ready                decode accepts if_instr this cycle
//   if_valid, if_instr      live instruction flag and registered instruction
//   if_pc4                  fetch address of if_instr plus 4
//   op, funct               if_instr[31:26] and if_instr[5:0]
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        ack;
  logic [31:0] addr_inc;
  logic [31:0] br_addr;

  // The skid entry is full exactly when the FSM is in STALL, so leaving
  // STALL (consume or redirect) is what empties it.
  assign imem_req  = rst_n && (state_q != STALL);
  assign imem_addr = addr_q;
  assign ack       = imem_ack && imem_req;
  assign addr_inc  = addr_q + 32'd4;
  assign br_addr   = br_target & 32'hFFFF_FFFC;

  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc4    = pc4_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tgt_d        = tgt_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    if (br_taken) begin
      valid_d = 1'b0;
      instr_d = NOP;
      pc4_d   = 32'h0;
      case (state_q)
        FETCH: begin
          if (ack) begin
            addr_d = br_addr;
          end else begin
            // Outstanding read must complete on its own address; park the
            // target until its response has been swallowed.
            tgt_d   = br_addr;
            state_d = DRAIN;
          end
        end
        STALL: begin
          addr_d  = br_addr;
          state_d = FETCH;
        end
        default: tgt_d = br_addr;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack) begin
            addr_d = addr_inc;
            if (!valid_q || id_ready) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              pc4_d   = addr_inc;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = addr_inc;
              state_d      = STALL;
            end
          end else if (id_ready) begin
            valid_d = 1'b0;
            instr_d = NOP;
          end
        end
        STALL: begin
          if (id_ready) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            pc4_d   = skid_pc4_q;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (ack) begin
            addr_d  = tgt_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      addr_q  <= RESET_ADDR;
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  // Payload-only registers: their contents are meaningless until the FSM
  // enters STALL or DRAIN, which always writes them first.
  always_ff @(posedge clk) begin
    tgt_q        <= tgt_d;
    skid_instr_q <= skid_instr_d;
    skid_pc4_q   <= skid_pc4_d;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address, bits [1:0] always 2'b00.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: read complete; imem_rdata is valid in this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 The block SHALL have port br_taken, input, 1 bit: redirect request (Branch AND Zero from EX).
REQ-009 The block SHALL have port br_target, input, 32 bits: redirect address; bits [1:0] are ignored.
REQ-010 The block SHALL have port id_ready, input, 1 bit: the decode stage accepts if_instr this cycle.
REQ-011 The block SHALL have port if_valid, output, 1 bit: if_instr and if_pc4 hold a live instruction.
REQ-012 The block SHALL have port if_instr, output, 32 bits: the registered instruction.
REQ-013 The block SHALL have port if_pc4, output, 32 bits: fetch address of if_instr plus 4.
REQ-014 The block SHALL have port op, output, 6 bits: if_instr[31:26], combinational, drives the controller Op input.
REQ-015 The block SHALL have port funct, output, 6 bits: if_instr[5:0], combinational.

Function
REQ-016 The block SHALL implement an FSM with three states: FETCH (imem_req=1), STALL (imem_req=0, skid full), and DRAIN (imem_req=1, response to be discarded).
REQ-017 The memory protocol SHALL be: imem_req and imem_addr stay stable from assertion until the imem_ack cycle inclusive; imem_ack is honoured only while imem_req=1.
REQ-018 In FETCH, on imem_ack with (!if_valid || id_ready), the block SHALL load if_instr<=imem_rdata, if_pc4<=imem_addr+4 and if_valid<=1, set the address to imem_addr+4, and stay in FETCH. Output is visible one cycle after ack.
REQ-019 In FETCH, on imem_ack with if_valid && !id_ready, the block SHALL load the data and pc4 into a one-entry skid register, set the address to imem_addr+4, and go to STALL.
REQ-020 In FETCH, when no ack arrives and id_ready=1, the block SHALL clear if_valid and load if_instr to 32'h0 (NOP).
REQ-021 In STALL, on id_ready, the block SHALL move the skid register to the output registers, set if_valid=1, and return to FETCH. Otherwise all outputs SHALL hold.
REQ-022 br_taken SHALL have priority over all non-reset events in every state.
REQ-023 On br_taken, the block SHALL clear if_valid, load if_instr<=32'h0 and if_pc4<=0, invalidate the skid, and record {br_target[31:2],2'b00} as the next address.
REQ-024 br_taken in FETCH without imem_ack SHALL cause a transition to DRAIN, holding the old imem_addr.
REQ-025 br_taken in FETCH with imem_ack SHALL discard imem_rdata, drive the target on imem_addr next cycle, and stay in FETCH.
REQ-026 br_taken in STALL SHALL cause a transition to FETCH at the target.
REQ-027 br_taken in DRAIN SHALL overwrite the recorded target and stay in DRAIN.
REQ-028 In DRAIN, on imem_ack, the block SHALL discard imem_rdata, present the recorded target on imem_addr, and go to FETCH.
REQ-029 A redirect SHALL never produce a valid output from a pre-redirect fetch.
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-031 id_ready while if_valid=0 SHALL have no effect.
REQ-032 An instruction SHALL never be dropped or duplicated absent a redirect.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL set state=FETCH, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0, if_pc4=32'h0, and mark the skid empty. imem_req SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_ack after reset is not expected and need not be handled.

Verification
REQ-035 Sequential fetch: RESET_PC=0, memory acks each request after 2 cycles, id_ready=1 -> addresses 0,4,8,12 are issued; if_pc4 sequence 4,8,12,16; op equals rdata[31:26] each time.
REQ-036 Backpressure: id_ready=0 for 3 cycles while 2 acks arrive -> the first word is held on output, the second goes to skid, imem_req=0 in STALL; on id_ready=1 the words appear in order with no loss.
REQ-037 Redirect during outstanding request: br_taken=1, br_target=32'h0000_0043 before ack -> DRAIN; the late ack data never reaches if_valid=1; the next request uses address 32'h0000_0040.
REQ-038 Simultaneous ack and br_taken: the acked word is discarded; the next cycle imem_addr equals the target and if_instr=0.
REQ-039 Wrap: address 32'hFFFF_FFFC acked -> if_pc4=32'h0, next imem_addr=32'h0.
REQ-040 Reset mid-STALL: rst_n=0 for one edge -> if_valid=0, skid empty, the fetch restarts at RESET_PC.
